reset_pulse_sequencer: RTL and testbench
========================================

Name: reset_pulse_sequencer

Overview:
- Multi-channel edge-to-pulse generator. Generalises the fixed per-instance edge detector / pulse extender used for the HPS cold, warm and debug reset requests.
- One instance serves all reset-request sources, with per-channel runtime pulse length, edge selection and retrigger policy.
- Optional mutual exclusion ensures at most one reset pulse reaches the HPS at a time.
- Sits between the source/probe reset-request bits and the soc_system f2h reset-request inputs.

Parameters:
CHANNELS, 3, number of independent request channels
CNT_WIDTH, 6, width of each pulse-length field and counter; maximum pulse is 2^CNT_WIDTH-1 cycles
EXCLUSIVE, 1, 1 = at most one channel's pulse_out high at any time (priority + pending); 0 = channels fully independent

Ports:
clk  in  1  single clock; all logic synchronous to its rising edge
reset  in  1  synchronous, active-high reset
signal_in  in  CHANNELS  request inputs, one per channel
edge_sel  in  2*CHANNELS  per channel: 00 disabled, 01 rising, 10 falling, 11 both
pulse_len  in  CHANNELS*CNT_WIDTH  per-channel pulse length in cycles; 0 treated as 1
retrig_en  in  CHANNELS  1 = an edge while active reloads the counter; 0 = the edge is ignored
pulse_out  out  CHANNELS  registered output pulses
done  out  CHANNELS  one-cycle strobe after each pulse ends
pend  out  CHANNELS  channel has a latched edge awaiting grant (EXCLUSIVE=1 only; otherwise constant 0)

Behaviour:
- Reset values: pulse_out, done and pend all 0. All counters 0. All channels IDLE.
- During reset, the prev register loads the sampled input, so an input held high across reset release produces no edge.
- Edge detection per channel: rise = s & ~prev, fall = ~s & prev, where s is the sampled input. Qualified by edge_sel. prev updates every cycle.
- Per-channel states:
  - IDLE: on a qualified edge at clock edge k, go to ACTIVE if granted, else to PENDING.
  - ACTIVE: counter loaded with L = max(pulse_len,1) at grant. pulse_out is high from after edge k through edge k+L, i.e. exactly L cycles. Counter decrements each cycle. When the counter reaches 1, the next edge moves the channel to IDLE and done = 1 for that one cycle.
  - PENDING: pend = 1. Moves to ACTIVE when granted.
- pulse_len is sampled only at counter load. Changes during a pulse have no effect. edge_sel changes do not affect an active pulse.
- Retrigger: a qualified edge in ACTIVE with retrig_en = 1 reloads L on that edge. The pulse is extended, with no gap and no done. With retrig_en = 0 the edge is dropped and not pended.
- EXCLUSIVE = 1, grant rule: a grant is issued only in a cycle where no channel is ACTIVE, including the cycle in which done is strobed. This guarantees at least one low cycle between pulses of different channels.
  - Among requesting channels (new edge or PENDING), the lowest index wins. Losers enter or stay in PENDING.
  - Pending depth is one: further edges on a PENDING channel are ignored.
  - edge_sel = 00 on a PENDING channel clears its pend.
- EXCLUSIVE = 0: every qualified IDLE edge is granted immediately. pend stays 0.
- Simultaneous edge and counter expiry on the same channel:
  - retrig_en = 1: reload, no done.
  - retrig_en = 0: expire normally with done. The edge is lost.
- Reset asserted mid-pulse: on the next edge, pulse_out, done and pend are 0 and counters are cleared. No done is emitted for the aborted pulse.

Optional Feature:
RESET_PULSE_SYNC_EN
- Defined: each signal_in bit passes through a 2-flop synchroniser (flops not reset) before edge detection. All latencies grow by 2 cycles. prev loads the synchroniser output during reset.
- Undefined: signal_in is assumed synchronous to clk and is sampled directly. Zero added latency.

Test Plan (CHANNELS=3, CNT_WIDTH=6, EXCLUSIVE=1, macro undefined unless noted):
1. ch0 edge_sel=01, pulse_len=6, signal_in[0] 0->1 sampled at edge k -> pulse_out[0] high for edges k+1..k+6 (6 cycles), done[0]=1 for 1 cycle, other outputs 0.
2. pulse_len=0, one rising edge -> pulse_out high exactly 1 cycle, then a done strobe.
3. pulse_len=4, second edge on the 3rd high cycle:
   - retrig_en=1 -> 6 contiguous high cycles, one done.
   - retrig_en=0 -> 4 high cycles, one done.
4. ch2 active with len 10; edges on ch0 and ch1 on the same clock at cycle 3 -> pend=3'b011. After ch2 done: ch0 pulse (pend[0] clears), 1 low cycle, then ch1 pulse. pulse_out never has two bits high.
5. reset high for 1 cycle at cycle 2 of a len-8 pulse -> all outputs 0 next cycle, no done. signal_in held 1 across release -> no new pulse.
6. edge_sel=11, len 3, signal_in 1->0, then 0->1 after 20 cycles -> two separate 3-cycle pulses. Repeat with RESET_PULSE_SYNC_EN defined -> same pulses shifted 2 cycles later.

Source files
------------

// File: rtl/reset_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// reset_pulse_sequencer
//
// Multi-channel edge-to-pulse generator for the HPS reset-request paths
// (cold, warm, debug and similar). Each channel watches one request bit,
// detects the selected edge(s) and turns each qualified edge into a pulse
// of programmable length, followed by a one-cycle done strobe.
//
// With EXCLUSIVE = 1 at most one channel drives its pulse at a time.
// Competing requests are arbitrated by lowest index. Losers are held in a
// one-deep pending slot, and there is always at least one low cycle between
// pulses of different channels.
//
// Optional build macro:
//   RESET_PULSE_SYNC_EN  - when defined, each signal_in bit passes through a
//                          2-flop synchroniser before edge detection. This
//                          adds 2 cycles to every latency.
//
// Parameters:
//   CHANNELS   number of independent request channels
//   CNT_WIDTH  width of each pulse-length field / counter
//   EXCLUSIVE  1 = one pulse at a time (priority + pending), 0 = independent
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset
//   signal_in  [CHANNELS]             request inputs
//   edge_sel   [2*CHANNELS]           per channel: 00 off, 01 rise,
//                                     10 fall, 11 both
//   pulse_len  [CHANNELS*CNT_WIDTH]   per-channel pulse length
//                                     (0 behaves as 1)
//   retrig_en  [CHANNELS]             1 = an edge while active reloads
//                                     the counter
//   pulse_out  [CHANNELS]             registered output pulses
//   done       [CHANNELS]             one-cycle strobe after each pulse
//   pend       [CHANNELS]             edge latched, waiting for grant
//                                     (EXCLUSIVE=1 only)
// -----------------------------------------------------------------------------
module reset_pulse_sequencer #(
   parameter int CHANNELS  = 3,
   parameter int CNT_WIDTH = 6,
   parameter int EXCLUSIVE = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           signal_in,
   input  logic [2*CHANNELS-1:0]         edge_sel,
   input  logic [CHANNELS*CNT_WIDTH-1:0] pulse_len,
   input  logic [CHANNELS-1:0]           retrig_en,
   output logic [CHANNELS-1:0]           pulse_out,
   output logic [CHANNELS-1:0]           done,
   output logic [CHANNELS-1:0]           pend
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_PENDING = 2'd2
   } chan_state_t;

   localparam logic [CHANNELS-1:0] ONE_VEC = CHANNELS'(1);

   logic [CHANNELS-1:0] sampled;
   logic [CHANNELS-1:0] prev_reg;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] qual_edge;
   logic [CHANNELS-1:0] sel_off;
   logic [CHANNELS-1:0] active_vec;
   logic [CHANNELS-1:0] req_vec;
   logic [CHANNELS-1:0] grant_vec;
   logic                any_active;

   logic [CHANNELS-1:0] pulse_out_reg;
   logic [CHANNELS-1:0] done_reg;
   logic [CHANNELS-1:0] pend_reg;

   // -------------------------------------------------------------------------
   // Input sampling
   // -------------------------------------------------------------------------
`ifdef RESET_PULSE_SYNC_EN
   // The synchroniser flops are deliberately not reset. They only carry
   // the input level, and they have to keep tracking it during reset so
   // that prev_reg sees the real level on release.
   logic [CHANNELS-1:0] sync1_reg;
   logic [CHANNELS-1:0] sync2_reg;

   always_ff @(posedge clk) begin
      sync1_reg <= signal_in;
      sync2_reg <= sync1_reg;
   end

   assign sampled = sync2_reg;
`else
   assign sampled = signal_in;
`endif

   // prev_reg follows the sampled input in every cycle, including reset.
   // As a result, a level held high across reset release is not seen as
   // an edge.
   always_ff @(posedge clk) begin
      prev_reg <= sampled;
   end

   assign rise = sampled & ~prev_reg;
   assign fall = ~sampled & prev_reg;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   // In exclusive mode a grant is only issued while no channel is ACTIVE.
   // A channel that expires on this edge is still ACTIVE in its state
   // register, so the next pulse cannot start before the done cycle.
   // req & -req isolates the lowest requesting index.
   always_comb begin
      any_active = |active_vec;
      grant_vec  = '0;
      if (EXCLUSIVE != 0) begin
         if (!any_active) begin
            grant_vec = req_vec & (~req_vec + ONE_VEC);
         end
      end else begin
         grant_vec = req_vec;
      end
   end

   // -------------------------------------------------------------------------
   // Per-channel state machines
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         chan_state_t          state_reg;
         chan_state_t          state_next;
         logic [CNT_WIDTH-1:0] cnt_reg;
         logic [CNT_WIDTH-1:0] cnt_next;
         logic [CNT_WIDTH-1:0] len_raw;
         logic [CNT_WIDTH-1:0] load_val;
         logic                 done_next;

         assign len_raw  = pulse_len[gi*CNT_WIDTH +: CNT_WIDTH];
         assign load_val = (len_raw == '0) ? CNT_WIDTH'(1) : len_raw;

         assign sel_off[gi]   = (edge_sel[2*gi +: 2] == 2'b00);
         assign qual_edge[gi] = (edge_sel[2*gi]   & rise[gi]) |
                                (edge_sel[2*gi+1] & fall[gi]);

         assign active_vec[gi] = (state_reg == ST_ACTIVE);

         // A pending channel whose edge selection has been switched off
         // drops its request in the same cycle it is cleared.
         assign req_vec[gi] = ((state_reg == ST_IDLE)    & qual_edge[gi]) |
                              ((state_reg == ST_PENDING) & ~sel_off[gi]);

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            done_next  = 1'b0;
            case (state_reg)
               ST_IDLE: begin
                  if (qual_edge[gi]) begin
                     if (grant_vec[gi]) begin
                        state_next = ST_ACTIVE;
                        cnt_next   = load_val;
                     end else begin
                        state_next = ST_PENDING;
                     end
                  end
               end

               ST_ACTIVE: begin
                  // A retrigger wins over expiry, so the pulse continues
                  // with no gap and no done strobe. Without retrigger the
                  // edge is simply lost.
                  if (qual_edge[gi] && retrig_en[gi]) begin
                     cnt_next = load_val;
                  end else if (cnt_reg <= CNT_WIDTH'(1)) begin
                     state_next = ST_IDLE;
                     cnt_next   = '0;
                     done_next  = 1'b1;
                  end else begin
                     cnt_next = cnt_reg - CNT_WIDTH'(1);
                  end
               end

               ST_PENDING: begin
                  // The pending depth is one, so new edges are ignored here.
                  if (sel_off[gi]) begin
                     state_next = ST_IDLE;
                  end else if (grant_vec[gi]) begin
                     state_next = ST_ACTIVE;
                     cnt_next   = load_val;
                  end
               end

               default: begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end
            endcase
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg         <= ST_IDLE;
               cnt_reg           <= '0;
               pulse_out_reg[gi] <= 1'b0;
               done_reg[gi]      <= 1'b0;
               pend_reg[gi]      <= 1'b0;
            end else begin
               state_reg         <= state_next;
               cnt_reg           <= cnt_next;
               pulse_out_reg[gi] <= (state_next == ST_ACTIVE);
               done_reg[gi]      <= done_next;
               pend_reg[gi]      <= (state_next == ST_PENDING);
            end
         end
      end
   endgenerate

   assign pulse_out = pulse_out_reg;
   assign done      = done_reg;
   assign pend      = pend_reg;

endmodule

// File: tb/tb_reset_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_pulse_sequencer
//
// Scoreboard bench for reset_pulse_sequencer (CHANNELS=3, CNT_WIDTH=6,
// EXCLUSIVE=1). Each stimulus sequence pushes its expected per-cycle output
// trace {pend, done, pulse_out} into a queue. A negedge monitor pops one
// entry per cycle and compares it with the DUT outputs.
//
// Entry 0 of every trace is the state before the first stimulus edge is
// sampled. When RESET_PULSE_SYNC_EN is defined, every trace is shifted by
// two cycles.
// -----------------------------------------------------------------------------
module tb_reset_pulse_sequencer;

   localparam int CH = 3;
   localparam int CW = 6;
`ifdef RESET_PULSE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [CH-1:0]  signal_in;
   logic [2*CH-1:0] edge_sel;
   logic [CH*CW-1:0] pulse_len;
   logic [CH-1:0]  retrig_en;
   logic [CH-1:0]  pulse_out;
   logic [CH-1:0]  done;
   logic [CH-1:0]  pend;

   reset_pulse_sequencer #(
      .CHANNELS  (CH),
      .CNT_WIDTH (CW),
      .EXCLUSIVE (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .signal_in (signal_in),
      .edge_sel  (edge_sel),
      .pulse_len (pulse_len),
      .retrig_en (retrig_en),
      .pulse_out (pulse_out),
      .done      (done),
      .pend      (pend)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [8:0] exp_q[$];
   string      tag_q[$];
   int         trace_pos;
   logic [8:0] mon_exp;
   string      mon_tag;

   task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("chk %-12s pend|done|pulse got=%b exp=%b ok", tag, got, exp);
      end else begin
         $display("FAIL %-12s pend|done|pulse got=%b exp=%b", tag, got, exp);
      end
   endtask

   // The monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         check_val(mon_tag, {pend, done, pulse_out}, mon_exp);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [2:0] p, input logic [2:0] d,
                       input logic [2:0] pn, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({pn, d, p});
         tag_q.push_back($sformatf("%s_c%0d", tag, trace_pos));
         trace_pos++;
      end
   endtask

   // Each trace starts with the pre-edge idle cycle, plus the sync latency.
   task automatic start_trace(input string tag);
      trace_pos = 0;
      push(tag, 3'b000, 3'b000, 3'b000, 1 + LAT);
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         step();
         k++;
      end
      if (exp_q.size() != 0) begin
         check_val("drain_timeout", 9'(exp_q.size()), 9'd0);
         exp_q.delete();
         tag_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      signal_in = '0;
      edge_sel  = '0;
      pulse_len = '0;
      retrig_en = '0;
      step();
      step();

      // Outputs while reset is held.
      trace_pos = 0;
      push("rst", 3'b000, 3'b000, 3'b000, 3);
      wait_drain(10);
      reset = 1'b0;
      step();
      step();

      // 1: ch0 rising, len 6.
      edge_sel       = 6'b00_00_01;
      pulse_len[5:0] = 6'd6;
      step();
      signal_in[0] = 1'b1;
      start_trace("t1");
      push("t1", 3'b001, 3'b000, 3'b000, 6);
      push("t1", 3'b000, 3'b001, 3'b000, 1);
      push("t1", 3'b000, 3'b000, 3'b000, 1);
      wait_drain(40);
      signal_in = '0;
      repeat (4) step();

      // 2: len 0 acts as len 1.
      pulse_len[5:0] = 6'd0;
      step();
      signal_in[0] = 1'b1;
      start_trace("t2");
      push("t2", 3'b001, 3'b000, 3'b000, 1);
      push("t2", 3'b000, 3'b001, 3'b000, 1);
      push("t2", 3'b000, 3'b000, 3'b000, 1);
      wait_drain(40);
      signal_in = '0;
      repeat (4) step();

      // 3a: len 4, retrigger on the 3rd high cycle, giving 6 high cycles.
      pulse_len[5:0] = 6'd4;
      retrig_en[0]   = 1'b1;
      step();
      signal_in[0] = 1'b1;
      start_trace("t3a");
      push("t3a", 3'b001, 3'b000, 3'b000, 6);
      push("t3a", 3'b000, 3'b001, 3'b000, 1);
      push("t3a", 3'b000, 3'b000, 3'b000, 1);
      step();
      signal_in[0] = 1'b0;
      step();
      signal_in[0] = 1'b1;
      wait_drain(40);
      signal_in = '0;
      repeat (4) step();

      // 3b: same stimulus without retrigger. The edge is dropped and not pended.
      retrig_en[0] = 1'b0;
      step();
      signal_in[0] = 1'b1;
      start_trace("t3b");
      push("t3b", 3'b001, 3'b000, 3'b000, 4);
      push("t3b", 3'b000, 3'b001, 3'b000, 1);
      push("t3b", 3'b000, 3'b000, 3'b000, 3);
      step();
      signal_in[0] = 1'b0;
      step();
      signal_in[0] = 1'b1;
      wait_drain(40);
      signal_in = '0;
      repeat (4) step();

      // 4: ch2 len 10 is active; ch0 and ch1 edges arrive on the same clock.
      edge_sel  = 6'b01_01_01;
      pulse_len = {6'd10, 6'd3, 6'd2};
      step();
      signal_in[2] = 1'b1;
      start_trace("t4");
      push("t4", 3'b100, 3'b000, 3'b000, 2);
      push("t4", 3'b100, 3'b000, 3'b011, 8);
      push("t4", 3'b000, 3'b100, 3'b011, 1);
      push("t4", 3'b001, 3'b000, 3'b010, 2);
      push("t4", 3'b000, 3'b001, 3'b010, 1);
      push("t4", 3'b010, 3'b000, 3'b000, 3);
      push("t4", 3'b000, 3'b010, 3'b000, 1);
      push("t4", 3'b000, 3'b000, 3'b000, 1);
      step();
      step();
      signal_in[1:0] = 2'b11;
      wait_drain(60);
      signal_in = '0;
      repeat (4) step();

      // 5: reset in pulse cycle 2 of a len-8 pulse, with the input held high.
      edge_sel       = 6'b00_00_01;
      pulse_len[5:0] = 6'd8;
      step();
      signal_in[0] = 1'b1;
      start_trace("t5");
      push("t5", 3'b001, 3'b000, 3'b000, 2);
      push("t5", 3'b000, 3'b000, 3'b000, 10);
      repeat (2 + LAT) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_drain(40);
      signal_in = '0;
      repeat (4) step();

      // 6: both edges, len 3. A fall and then a rise 20 cycles later.
      edge_sel       = 6'b00_00_00;
      pulse_len[5:0] = 6'd3;
      signal_in[0]   = 1'b1;
      repeat (5) step();
      edge_sel = 6'b00_00_11;
      repeat (2) step();
      signal_in[0] = 1'b0;
      start_trace("t6");
      push("t6", 3'b001, 3'b000, 3'b000, 3);
      push("t6", 3'b000, 3'b001, 3'b000, 1);
      push("t6", 3'b000, 3'b000, 3'b000, 16);
      push("t6", 3'b001, 3'b000, 3'b000, 3);
      push("t6", 3'b000, 3'b001, 3'b000, 1);
      push("t6", 3'b000, 3'b000, 3'b000, 1);
      repeat (20) step();
      signal_in[0] = 1'b1;
      wait_drain(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
